// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths,
// master identifiers and the byte-mask value that denotes a read.
package dm_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/dm_arb_pick.sv
// Winner selection for the two-master arbiter.
// Macro DM_ARB_RR_EN: defined -> round-robin on contention (the master that
// was not granted last wins); undefined -> fixed priority (master 0 wins).
// A lone requester always wins in either mode.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_any,
    output logic o_winner
);

`ifndef DM_ARB_RR_EN
    // Fixed priority ignores the history register; keep it visibly consumed.
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

    // Pick the winner from the current requests (and history in round-robin).
    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = M0;
`ifdef DM_ARB_RR_EN
        if (i_req0 && i_req1) begin
            o_winner = ~i_last;
        end else if (i_req1) begin
            o_winner = M1;
        end
`else
        if (!i_req0 && i_req1) begin
            o_winner = M1;
        end
`endif
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter sharing the single DM_Core BRAM port.
// Macro DM_ARB_RR_EN selects round-robin arbitration (see dm_arb_pick);
// without it master 0 has fixed priority.
// Handshake: a master holds req (with stable we/addr/wdata) until it sees gnt
// in the same cycle; the access is accepted in that cycle. A granted read
// returns data with a one-cycle rvalid pulse in the following cycle.
module dm_arbiter
#(
    parameter int ADDR_W = dm_arb_pkg::ADDR_W,
    parameter int DATA_W = dm_arb_pkg::DATA_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              dm_ena,
    output logic [3:0]        dm_wea,
    output logic [ADDR_W-1:0] dm_addra,
    output logic [DATA_W-1:0] dm_dina,
    input  logic [DATA_W-1:0] dm_douta
);

    import dm_arb_pkg::*;

    logic       w_any;
    logic       w_winner;
    logic       w_grant;
    logic [3:0] w_sel_we;
    logic       r_last;
    logic       r_pend_valid;
    logic       r_pend_id;

    dm_arb_pick u_pick (
        .i_req0   (m0_req),
        .i_req1   (m1_req),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // Grants are suppressed while reset is held.
    assign w_grant = w_any & ~reset;

    // Route the winner's access onto the BRAM port and raise its grant.
    always_comb begin
        m0_gnt   = w_grant & (w_winner == M0);
        m1_gnt   = w_grant & (w_winner == M1);
        w_sel_we = (w_winner == M1) ? m1_we : m0_we;
        dm_ena   = w_grant;
        dm_wea   = w_grant ? w_sel_we : WE_READ;
        dm_addra = (w_winner == M1) ? m1_addr : m0_addr;
        dm_dina  = (w_winner == M1) ? m1_wdata : m0_wdata;
    end

    // Track the last granted master and the owner of an in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last       <= M1;
            r_pend_valid <= 1'b0;
            r_pend_id    <= M0;
        end else begin
            r_pend_valid <= w_grant && (w_sel_we == WE_READ);
            if (w_grant) begin
                r_last    <= w_winner;
                r_pend_id <= w_winner;
            end
        end
    end

    // Read return: a read accepted just before reset rises is dropped.
    always_comb begin
        m0_rvalid = r_pend_valid & ~reset & (r_pend_id == M0);
        m1_rvalid = r_pend_valid & ~reset & (r_pend_id == M1);
        m0_rdata  = dm_douta;
        m1_rdata  = dm_douta;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: queued requesters, a BRAM stand-in, a reference
// model of arbitration and memory contents, and a read-return monitor.
module tb_dm_arbiter;

    import dm_arb_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

`ifdef DM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } tx_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          m0_req, m1_req;
    logic [3:0]    m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          dm_ena;
    logic [3:0]    dm_wea;
    logic [AW-1:0] dm_addra;
    logic [DW-1:0] dm_dina, dm_douta;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .dm_ena(dm_ena), .dm_wea(dm_wea), .dm_addra(dm_addra), .dm_dina(dm_dina),
        .dm_douta(dm_douta)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [3:0] we);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- BRAM stand-in (1-cycle registered read) ----------------
    logic [DW-1:0] bram [0:2047];
    always @(posedge clk) begin
        if (dm_ena) begin
            dm_douta <= bram[dm_addra];
            bram[dm_addra] <= merge(bram[dm_addra], dm_dina, dm_wea);
        end
    end

    // ---------------- check bookkeeping ----------------
    int n_total = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- drivers ----------------
    tx_t txq0[$], txq1[$];
    tx_t cur0 = '0, cur1 = '0;
    logic cur_v0 = 1'b0, cur_v1 = 1'b0;
    logic taken0 = 1'b0, taken1 = 1'b0;
    int g0 = 0, g1 = 0;

    task automatic push(input int m, input logic [3:0] we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        tx_t t;
        t.we = we; t.addr = a; t.data = d;
        if (m == 0) txq0.push_back(t);
        else txq1.push_back(t);
    endtask

    always @(posedge clk) begin
        #1;
        if (cur_v0 && taken0) cur_v0 = 1'b0;
        if (!cur_v0 && txq0.size() > 0) begin cur0 = txq0.pop_front(); cur_v0 = 1'b1; end
        if (cur_v1 && taken1) cur_v1 = 1'b0;
        if (!cur_v1 && txq1.size() > 0) begin cur1 = txq1.pop_front(); cur_v1 = 1'b1; end
        m0_req = cur_v0;
        m0_we = cur_v0 ? cur0.we : 4'h0;
        m0_addr = cur_v0 ? cur0.addr : '0;
        m0_wdata = cur_v0 ? cur0.data : '0;
        m1_req = cur_v1;
        m1_we = cur_v1 ? cur1.we : 4'h0;
        m1_addr = cur_v1 ? cur1.addr : '0;
        m1_wdata = cur_v1 ? cur1.data : '0;
    end

    // ---------------- reference model + grant checks ----------------
    logic [DW-1:0] ref_mem [0:2047];
    logic [DW-1:0] exp_q0[$], exp_q1[$];
    int due_q0[$], due_q1[$];
    logic mdl_last = 1'b1;

    always @(negedge clk) begin
        logic win, any;
        tx_t t;
        taken0 = m0_gnt;
        taken1 = m1_gnt;
        if (m0_gnt) g0++;
        if (m1_gnt) g1++;
        if (reset) begin
            chk("gnt_in_reset", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            chk("ena_in_reset", dm_ena, 1'b0);
            chk("wea_in_reset", dm_wea, 4'h0);
            mdl_last = 1'b1;
        end else begin
            any = m0_req | m1_req;
            if (m0_req && m1_req) win = RR ? ~mdl_last : 1'b0;
            else win = m1_req;
            chk("gnt", {30'd0, m1_gnt, m0_gnt}, !any ? 32'd0 : (win ? 32'd2 : 32'd1));
            chk("dm_ena", dm_ena, any);
            if (any) begin
                t = win ? cur1 : cur0;
                chk("dm_wea", dm_wea, t.we);
                chk("dm_addra", dm_addra, t.addr);
                chk("dm_dina", dm_dina, t.data);
                if (t.we == 4'h0) begin
                    if (win) begin exp_q1.push_back(ref_mem[t.addr]); due_q1.push_back(cyc + 1); end
                    else begin exp_q0.push_back(ref_mem[t.addr]); due_q0.push_back(cyc + 1); end
                end else begin
                    ref_mem[t.addr] = merge(ref_mem[t.addr], t.data, t.we);
                end
                mdl_last = win;
            end else begin
                chk("dm_wea_idle", dm_wea, 4'h0);
            end
        end
    end

    // ---------------- read-return monitor ----------------
    logic [DW-1:0] last_rdata0 = '0, last_rdata1 = '0;

    always @(negedge clk) begin
        logic due;
        logic [DW-1:0] e;
        e = '0;
        due = (exp_q0.size() > 0) && (due_q0[0] == cyc);
        if (due) begin e = exp_q0.pop_front(); void'(due_q0.pop_front()); end
        if (reset || !due) chk("m0_rvalid_low", m0_rvalid, 1'b0);
        else begin
            chk("m0_rvalid", m0_rvalid, 1'b1);
            chk("m0_rdata", m0_rdata, e);
            last_rdata0 = m0_rdata;
        end
        e = '0;
        due = (exp_q1.size() > 0) && (due_q1[0] == cyc);
        if (due) begin e = exp_q1.pop_front(); void'(due_q1.pop_front()); end
        if (reset || !due) chk("m1_rvalid_low", m1_rvalid, 1'b0);
        else begin
            chk("m1_rvalid", m1_rvalid, 1'b1);
            chk("m1_rdata", m1_rdata, e);
            last_rdata1 = m1_rdata;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((txq0.size() > 0 || txq1.size() > 0 || cur_v0 || cur_v1 ||
                exp_q0.size() > 0 || exp_q1.size() > 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", (k < budget), 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_gnt(input int m, input int budget);
        int k, start;
        k = 0;
        start = (m == 0) ? g0 : g1;
        while (((m == 0) ? g0 : g1) == start && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("gnt_timeout", (k < budget), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        for (int i = 0; i < 2048; i++) begin bram[i] = '0; ref_mem[i] = '0; end
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        reset = 1'b1;

        // Contention from reset: both hold reads (addr 5 / addr 6).
        push(0, 4'h0, 11'd5, 32'd0); push(0, 4'h0, 11'd5, 32'd0);
        push(1, 4'h0, 11'd6, 32'd0); push(1, 4'h0, 11'd6, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_idle(50);

        // Byte-masked write then read.
        push(0, 4'b1100, 11'd1002, 32'h12345678);
        push(0, 4'h0, 11'd1002, 32'd0);
        wait_idle(50);
        chk("bytemask_rdata", last_rdata0, 32'h12340000);

        // Single requester m1 reads 0..3 back to back (distinct contents).
        for (int a = 0; a < 4; a++) push(0, 4'hF, 11'(a), 32'hA0 + 32'(a));
        wait_idle(50);
        for (int a = 0; a < 4; a++) push(1, 4'h0, 11'(a), 32'd0);
        wait_idle(50);
        chk("single_last_rdata", last_rdata1, 32'hA3);

        // Write gives no rvalid; m0 reads it the next cycle.
        push(1, 4'hF, 11'd7, 32'hDEADBEEF);
        wait_gnt(1, 20);
        push(0, 4'h0, 11'd7, 32'd0);
        wait_idle(50);
        chk("write_then_read", last_rdata0, 32'hDEADBEEF);

        // Reset in the cycle after a granted m0 read.
        push(0, 4'h0, 11'd1002, 32'd0);
        wait_gnt(0, 20);
        @(posedge clk);
        #2 reset = 1'b1;
        push(0, 4'h0, 11'd5, 32'd0);
        push(1, 4'h0, 11'd6, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        wait_idle(50);

        // Randomized traffic on a small address window.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 2) == 0 && txq0.size() < 2)
                push(0, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                     11'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) == 0 && txq1.size() < 2)
                push(1, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                     11'($urandom_range(0, 15)), $urandom);
        end
        wait_idle(300);

        chk("exp_q0_drained", exp_q0.size(), 0);
        chk("exp_q1_drained", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter in front of the `DM_Core` data-memory block RAM. It lets the CPU data port (master 0) and the debug/loader port (master 1) share the single BRAM port. Each cycle it grants at most one request and drives the BRAM enable, byte-write mask, address and write data. One cycle later it returns read data to the master that issued the read. It sits between the CPU/loader and `DM_Core` in the calculator top level.

## Interface
- `ADDR_W`, 11, word address width (matches `addra`)
- `DATA_W`, 32, data width
- `clk` in 1: single clock, also drives `DM_Core.clka`
- `reset` in 1: synchronous, active-high
- `m0_req` / `m1_req` in 1: request; held until granted
- `m0_we` / `m1_we` in 4: byte-write mask; `4'b0000` means read
- `m0_addr` / `m1_addr` in ADDR_W: word address
- `m0_wdata` / `m1_wdata` in DATA_W: write data
- `m0_gnt` / `m1_gnt` out 1: request accepted this cycle (combinational)
- `m0_rvalid` / `m1_rvalid` out 1: read data valid (registered)
- `m0_rdata` / `m1_rdata` out DATA_W: read data; equals `dm_douta`, meaningful only while rvalid is high
- `dm_ena` out 1, `dm_wea` out 4, `dm_addra` out ADDR_W, `dm_dina` out DATA_W: to `DM_Core`
- `dm_douta` in DATA_W: from `DM_Core`

## Operation
- **Grant.** A master is granted when its req is high and it wins arbitration. At most one gnt is high per cycle. A winner always exists if any req is high.
- **BRAM drive.** The granted master's we/addr/wdata go to `dm_wea`/`dm_addra`/`dm_dina`, and `dm_ena=1`. With no grant: `dm_ena=0`, `dm_wea=0`, address and data are don't-care.
- **Arbitration.** Round-robin or fixed priority; see Configuration.
- **Priority state.** A `last` register records the most recently granted master. It updates only on a grant.
- **Read return pipeline.** On a granted read (we==0), register `pend_valid=1` and `pend_id=winner`. Next cycle, the `pend_id` master sees rvalid=1 for exactly one cycle.
- **Writes.** Granted writes never produce rvalid.
- **Back-to-back.** Reads from alternating masters in consecutive cycles return back-to-back with correct routing.
- **Requester contract.** A requester drops req, or presents its next request, the cycle after gnt. An ungranted req must stay stable.
- **Reset.** Reset clears `pend_valid` and sets `last=1`, so master 0 wins the first contested cycle. A read granted in the reset cycle is discarded and gets no rvalid.

## Timing
- Reset values: `m0_gnt=m1_gnt=0` while reset=1 (grants suppressed); `m0_rvalid=m1_rvalid=0`; `dm_ena=0`; `dm_wea=0`.
- Grant latency: 0 cycles (gnt in the same cycle as req when the master wins).
- Read latency: granted in cycle N, rvalid and data in cycle N+1. This matches the 1-cycle registered output of `DM_Core`.
- Write takes effect at the clock edge ending the grant cycle. A read of the same address granted in N+1 returns the new data in N+2.
- Throughput: one access per cycle total, shared by both masters.
- Starvation bound in round-robin mode: a held request is granted within 2 cycles.

## Configuration
- **`DM_ARB_RR_EN` defined:** round-robin.
  - On contention, grant the master not equal to `last`.
  - A single requester always wins.
- **`DM_ARB_RR_EN` undefined:** fixed priority.
  - Master 0 always wins contention.
  - The `last` register is still present but not used for the decision.
- The pipeline and port behaviour are identical in both modes.

## Structure
- Shared package `dm_arb_pkg`:
  - `ADDR_W` and `DATA_W` defaults
  - master-id constants `M0=1'b0`, `M1=1'b1`
  - `WE_READ=4'b0000`
- One sub-module, `dm_arb_pick`: combinational winner selection from (req0, req1, last). This is the only code that differs under `DM_ARB_RR_EN`.
- `DM_Core` is instantiated at the top level, not inside this block.

## Test plan
- **Byte-masked write then read (BRAM zero-initialised):** m0 writes addr 1002, we=4'b1100, data 32'h12345678. m0 then reads 1002. Required: `m0_rdata=32'h12340000` with `m0_rvalid` one cycle after gnt, and `m1_rvalid=0`.
- **Contention, round-robin:** m0 and m1 both hold read requests (addr 5 and addr 6) for 4 cycles from reset. Required: grants go m0, m1, m0, m1, each with rvalid to the matching master one cycle later. Without the macro: m0 every cycle.
- **Single requester:** m1 alone reads addrs 0..3 on consecutive cycles. Required: gnt every cycle and 4 consecutive rvalid pulses in address order.
- **Write gives no rvalid:** m1 writes addr 7, we=4'b1111, data 32'hDEADBEEF. Required: `m1_gnt=1`, no rvalid. An m0 read of addr 7 on the next cycle returns 32'hDEADBEEF.
- **Reset mid-read:** assert reset in the cycle after a granted m0 read. Required: `m0_rvalid=0` and no grants during reset. After release, contention grants m0 first.
